rgb_ctrl_axil_slave: RTL and testbench
======================================

# rgb_ctrl_axil_slave

AXI4-Lite slave register file that terminates the host-side control bus of the RGB888-to-RGB565 converter IP. It is the responder to the AXI4-Lite master driving the converter's S00_AXI port. It holds four 32-bit read/write registers, applies byte strobes, and exports register contents and per-register write pulses to the pixel datapath. It accepts one write and one read at a time, with independent AW/W capture and full B/R backpressure.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register; addr[1:0] ignored.
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg_out  out  128  {reg3, reg2, reg1, reg0} to the datapath.
- reg_wr_pulse  out  4  one-cycle strobe, bit n set in the cycle after regn is written.

## Operation
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: AWREADY=1, WREADY=1. If both handshakes occur in one cycle, go to RESP. AW only goes to HAVE_AW; W only goes to HAVE_W.
  - HAVE_AW: AWREADY=0, WREADY=1. A W handshake goes to RESP.
  - HAVE_W: WREADY=0, AWREADY=1. An AW handshake goes to RESP.
  - Commit: on entry to RESP, the captured address and data are written to the register; byte k is updated only where WSTRB[k]=1. BVALID=1 and reg_wr_pulse[idx]=1 for that one cycle.
  - RESP: AWREADY=WREADY=0. Hold BVALID until BREADY=1, then return to IDLE.
  - WSTRB=0 still completes with OKAY; the register is unchanged but reg_wr_pulse still fires.
- Read path, independent of the write path:
  - ARREADY = !RVALID.
  - AR handshake: next cycle RVALID=1, RDATA = register[araddr[3:2]].
  - RDATA is held stable until RREADY=1, then RVALID drops.
  - If the read address is captured in the same cycle as a write commit to the same register, RDATA returns the pre-write value.
- No SLVERR/DECERR is generated. All 4 index values are valid.

## Timing
- Reset (async assert, sync release): all registers 0; reg_out=0; reg_wr_pulse=0; BVALID=0; RVALID=0; RDATA=0; AWREADY=WREADY=ARREADY=0.
- First cycle after ARESET deasserts: AWREADY=WREADY=ARREADY=1.
- Write latency: AW+W same cycle at edge N gives BVALID=1 and the register updated at N+1. reg_out reflects the new value from N+1.
- Read latency: AR at edge N gives RVALID at N+1. Back-to-back reads with RREADY tied high give one read per 2 cycles.
- Write throughput with BREADY tied high: one write per 2 cycles.
- Reset mid-transaction: pending AW/W/B/R state is dropped immediately, with no response issued.
- VALID is never gated by READY on slave outputs. BVALID and RVALID never drop without a handshake.

## Test plan
- Sequential: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read back -> RDATA 0x1, 0x2, 0x3, 0x4, RRESP=0, BRESP=0, reg_out=0x00000004_00000003_00000002_00000001.
- AW issued 3 cycles before W (addr 0x8, data 0xDEADBEEF) -> AWREADY low from the AW handshake until the write completes; BVALID one cycle after the W handshake; reg2=0xDEADBEEF; reg_wr_pulse=4'b0100 for exactly one cycle.
- Byte strobe: reg1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg1=0xFF34FF78.
- Backpressure: BREADY low 5 cycles, RREADY low 5 cycles -> BVALID/RVALID and RDATA held stable; no new AW/W/AR accepted until the response handshake completes.
- Read of reg0 captured in the same cycle as a write commit of 0xA5 to reg0 (old value 0x1) -> RDATA=0x1; a following read returns 0xA5.
- Assert ARESET while in HAVE_AW and with RVALID pending -> all outputs 0 asynchronously; after release, registers read 0 and a new write completes normally.

Source files
------------

// File: rtl/rgb_ctrl_axil_slave.sv
// AXI4-Lite register file for the RGB888-to-RGB565 converter control bus.
// Four 32-bit R/W registers with byte strobes, exported with per-register write pulses.
module rgb_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    reg_out,
  output logic [3:0]                      reg_wr_pulse
);

  // state      | meaning
  // ST_IDLE    | waiting for AW and/or W
  // ST_HAVE_AW | address captured, waiting for W
  // ST_HAVE_W  | data captured, waiting for AW
  // ST_RESP    | register committed, holding BVALID until BREADY
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HAVE_AW = 2'd1;
  localparam logic [1:0] ST_HAVE_W  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]        state, next_state;
  logic              live;
  logic [3:0][31:0]  regs;
  logic [1:0]        aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [1:0]        wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready outputs stay low until the first clock after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign S_AXI_AWREADY = live && ((state == ST_IDLE) || (state == ST_HAVE_W));
  assign S_AXI_WREADY  = live && ((state == ST_IDLE) || (state == ST_HAVE_AW));
  assign S_AXI_BVALID  = (state == ST_RESP);
  assign S_AXI_BRESP   = 2'b00;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (aw_hs && w_hs) next_state = ST_RESP;
        else if (aw_hs)    next_state = ST_HAVE_AW;
        else if (w_hs)     next_state = ST_HAVE_W;
      end
      ST_HAVE_AW: if (w_hs)  next_state = ST_RESP;
      ST_HAVE_W:  if (aw_hs) next_state = ST_RESP;
      ST_RESP:    if (S_AXI_BREADY) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  assign commit  = (next_state == ST_RESP) && (state != ST_RESP);
  assign wr_idx  = (state == ST_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = (state == ST_HAVE_W)  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = (state == ST_HAVE_W)  ? w_strb_q : S_AXI_WSTRB;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= ST_IDLE;
      aw_idx_q <= 2'd0;
      w_data_q <= 32'd0;
      w_strb_q <= 4'd0;
    end else begin
      state <= next_state;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs         <= '0;
      reg_wr_pulse <= 4'd0;
    end else begin
      reg_wr_pulse <= commit ? (4'b0001 << wr_idx) : 4'd0;
      if (commit) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign reg_out = regs;

  // Read samples regs before any same-edge commit lands, so it returns the old value.
  assign S_AXI_ARREADY = live && !rvalid;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = 2'b00;

endmodule

// File: tb/tb_rgb_ctrl_axil_slave.sv
// Directed bench for rgb_ctrl_axil_slave; read data checked against a queue of expected values.
module tb_rgb_ctrl_axil_slave;

  logic         clk, rst;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, pulse;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  rgb_ctrl_axil_slave dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int  n;
    bit  aw_done, w_done, aw_hs, w_hs;
    logic [3:0] exp_pulse;
    exp_pulse = 4'b0001 << addr[3:2];
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", {127'd0, aw_done && w_done}, 128'd1);
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, 2'b00);
    chk("wr_pulse", pulse, exp_pulse);
    if (bready) begin
      step();
      chk("bvalid_drop", bvalid, 1'b0);
      chk("pulse_clear", pulse, 4'd0);
    end
  endtask

  task automatic get_r(input string tag);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    chk("rvalid", rvalid, 1'b1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk(tag, rdata, exp);
    end
    chk("rresp", rresp, 2'b00);
    if (rready) step();
  endtask

  task automatic axil_read(input logic [3:0] addr, input logic [31:0] exp);
    int n;
    bit done, hs;
    exp_q.push_back(exp);
    araddr = addr; arvalid = 1'b1;
    done = 0; n = 0;
    while (!done && n < 50) begin
      hs = arvalid && arready;
      step();
      if (hs) begin done = 1; arvalid = 1'b0; end
      n++;
    end
    arvalid = 1'b0;
    chk("ar_handshake", {127'd0, done}, 128'd1);
    get_r("rdata");
  endtask

  initial begin
    rst = 1'b1;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; wdata = 0; wstrb = 0;
    bready = 1; rready = 1;

    #22;
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_reg_out", reg_out, 128'd0);
    chk("rst_pulse", pulse, 4'd0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Sequential writes and read-back
    for (int i = 0; i < 4; i++) axil_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axil_read(4'(i * 4), 32'(i + 1));
    chk("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

    // AW three cycles ahead of W
    awaddr = 4'h8; awvalid = 1'b1;
    chk("aw_first_ready", awready, 1'b1);
    step(); awvalid = 1'b0;
    chk("aw_blocked", awready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("aw_wait_awready", awready, 1'b0);
      chk("aw_wait_bvalid", bvalid, 1'b0);
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    chk("late_w_wready", wready, 1'b1);
    step(); wvalid = 1'b0;
    chk("late_w_bvalid", bvalid, 1'b1);
    chk("late_w_pulse", pulse, 4'b0100);
    chk("late_w_reg2", reg_out[95:64], 32'hDEADBEEF);
    chk("late_w_awready", awready, 1'b0);
    step();
    chk("late_w_pulse_clear", pulse, 4'd0);
    chk("late_w_bdone", bvalid, 1'b0);

    // Byte strobes
    axil_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axil_write(4'h4, 32'h12345678, 4'b0101);
    axil_read(4'h4, 32'hFF34FF78);
    axil_write(4'h4, 32'h00000000, 4'b0000);
    axil_read(4'h4, 32'hFF34FF78);

    // Write response backpressure
    bready = 1'b0;
    axil_write(4'hC, 32'h00000055, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_wr_readies", {awready, wready}, 2'b00);
      chk("bp_pulse_once", pulse, 4'd0);
    end
    bready = 1'b1;
    step();
    chk("bp_bvalid_done", bvalid, 1'b0);

    // Read data backpressure
    rready = 1'b0;
    axil_read(4'hC, 32'h00000055);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rvalid", rvalid, 1'b1);
      chk("bp_rdata", rdata, 32'h00000055);
      chk("bp_arready", arready, 1'b0);
    end
    rready = 1'b1;
    step();
    chk("bp_rvalid_done", rvalid, 1'b0);

    // Read captured on the same edge as a write commit to the same register
    awaddr = 4'h0; wdata = 32'h000000A5; wstrb = 4'hF; araddr = 4'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    chk("coll_readies", {awready, wready, arready}, 3'b111);
    exp_q.push_back(32'h00000001);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_bvalid", bvalid, 1'b1);
    get_r("coll_old_value");
    axil_read(4'h0, 32'h000000A5);

    // Reset with a write address pending and read data pending
    awaddr = 4'h4; awvalid = 1'b1;
    step(); awvalid = 1'b0;
    rready = 1'b0; araddr = 4'h0; arvalid = 1'b1;
    step(); arvalid = 1'b0;
    chk("pre_rst_rvalid", rvalid, 1'b1);
    chk("pre_rst_awready", awready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
    chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_reg_out", reg_out, 128'd0);
    chk("mid_rst_pulse", pulse, 4'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    rready = 1'b1;
    step();
    chk("post_mid_rst_readies", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 4; i++) axil_read(4'(i * 4), 32'd0);
    axil_write(4'h8, 32'h00000077, 4'hF);
    axil_read(4'h8, 32'h00000077);
    chk("final_reg_out", reg_out, {32'd0, 32'h77, 32'd0, 32'd0});
    chk("queue_empty", {96'd0, 32'(exp_q.size())}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
